dataram_arbiter: RTL

//   Shares the single-port SPRAM data memory between the rj32 CPU (port C) and one

---
 rtl/dataram_arbiter.sv | 68 ++++++
 1 files changed

// File: rtl/dataram_arbiter.sv
// dataram_arbiter: shares the single-port data SPRAM between the CPU (priority) and an auxiliary requester B
// Ports: clock/reset; CPU side cpu_req/we/addr/wdata -> cpu_wait/rdata/rvalid;
//        B side b_req/we/addr/wdata -> b_gnt/rdata/rvalid; SPRAM side mem_addr/wdata/we <- mem_rdata.
module dataram_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_wait,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);
    typedef enum logic {S_PRI, S_FORCE} state_t;
    typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_B} owner_t;
    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX - 1);
    state_t state, state_next;
    owner_t rd_owner, rd_next;
    logic [3:0] starve_cnt, starve_next;
    logic [AW-1:0] addr_q;
    logic cpu_gnt;
    always_comb begin
        cpu_gnt     = !reset && state == S_PRI && cpu_req;
        b_gnt       = !reset && b_req && (state == S_FORCE || !cpu_req);
        cpu_wait    = !reset && state == S_FORCE && cpu_req;
        mem_we      = cpu_gnt ? cpu_we : b_gnt && b_we;
        // idle slots keep the previous address on the SPRAM pins
        mem_addr    = cpu_gnt ? cpu_addr : b_gnt ? b_addr : addr_q;
        mem_wdata   = cpu_gnt ? cpu_wdata : b_wdata;
        state_next  = (state == S_PRI && b_req && !b_gnt && starve_cnt == CNT_MAX) ? S_FORCE : S_PRI;
        starve_next = (b_req && !b_gnt) ? (starve_cnt == CNT_MAX ? starve_cnt : starve_cnt + 4'd1) : 4'd0;
        rd_next     = (cpu_gnt && !cpu_we) ? RD_CPU : (b_gnt && !b_we) ? RD_B : RD_NONE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_PRI;
            starve_cnt <= 4'd0;
            rd_owner   <= RD_NONE;
            addr_q     <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            rd_owner   <= rd_next;
            addr_q     <= mem_addr;
        end
    end
    // gating with reset discards a read whose data lands while reset is high
    assign cpu_rvalid = !reset && rd_owner == RD_CPU;
    assign b_rvalid   = !reset && rd_owner == RD_B;
    assign cpu_rdata  = mem_rdata;
    assign b_rdata    = mem_rdata;
endmodule
